// File: rtl/demux_8bits_buf_pkg.sv
// Shared definitions for the 8-bit mux/demux family: channel indices and the
// three-select decode used by both the mux and this demultiplexer.
package demux_8bits_buf_pkg;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

    // sel3 picks the group; within a group only that group's select bit counts.
    function automatic logic [1:0] decode_sel(input logic sel1,
                                              input logic sel2,
                                              input logic sel3);
        if (sel3)
            return sel2 ? CH_D : CH_C;
        else
            return sel1 ? CH_B : CH_A;
    endfunction

endpackage

// File: rtl/demux_8bits_buf_slot.sv
// One-entry holding register for a single demux output channel.
module demux_8bits_buf_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    // A load in the same cycle as a drain keeps the slot full with the new byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
        end else if (r_full && i_ready) begin
            r_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule

// File: rtl/demux_8bits_buf.sv
// Buffered 1-to-4 byte demultiplexer with per-channel valid/ready.
// Optional per-channel handshake counters are enabled by DEMUX_BUF_CNT_EN.
module demux_8bits_buf
    import demux_8bits_buf_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sel1,
    input  logic             sel2,
    input  logic             sel3,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready
`ifdef DEMUX_BUF_CNT_EN
    ,
    output logic [4*WIDTH-1:0] cnt
`endif
);

    logic [1:0]       w_tgt;
    logic [3:0]       w_full;
    logic [3:0]       w_load;
    logic [WIDTH-1:0] w_data [4];

    assign w_tgt    = decode_sel(sel1, sel2, sel3);
    assign in_ready = !rst && (!w_full[w_tgt] || out_ready[w_tgt]);

    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
        assign w_load[gi] = in_valid && in_ready && (w_tgt == 2'(gi));

        demux_8bits_buf_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_load[gi]),
            .i_data  (in_data),
            .i_ready (out_ready[gi]),
            .o_full  (w_full[gi]),
            .o_data  (w_data[gi])
        );
    end

    assign out_valid = w_full;
    assign a = w_data[CH_A];
    assign b = w_data[CH_B];
    assign c = w_data[CH_C];
    assign d = w_data[CH_D];

`ifdef DEMUX_BUF_CNT_EN
    logic [WIDTH-1:0] r_cnt [4];

    // Counters wrap naturally at 2^WIDTH.
    for (genvar gk = 0; gk < 4; gk++) begin : g_cnt
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt[gk] <= '0;
            end else if (w_full[gk] && out_ready[gk]) begin
                r_cnt[gk] <= r_cnt[gk] + 1'b1;
            end
        end
        assign cnt[gk*WIDTH +: WIDTH] = r_cnt[gk];
    end
`endif

endmodule

// File: tb/tb_demux_8bits_buf.sv
// Directed self-checking bench for demux_8bits_buf (counter section runs when
// DEMUX_BUF_CNT_EN is defined).
module tb_demux_8bits_buf;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             sel1, sel2, sel3;
    logic [WIDTH-1:0] a, b, c, d;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
`ifdef DEMUX_BUF_CNT_EN
    logic [4*WIDTH-1:0] cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    demux_8bits_buf #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel1      (sel1),
        .sel2      (sel2),
        .sel3      (sel3),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX_BUF_CNT_EN
        ,
        .cnt       (cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] chan(input int k);
        case (k)
            0:       return a;
            1:       return b;
            2:       return c;
            default: return d;
        endcase
    endfunction

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // Hand-decoded targets for {sel1,sel2,sel3} = i (sel1 = i[2], sel3 = i[0]).
    int walk_ch [8] = '{0, 2, 0, 3, 1, 2, 1, 3};

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 1'b0;
        sel1 = 1'b0; sel2 = 1'b0; sel3 = 1'b0; out_ready = 4'b0000;
        #2;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_abcd", {a, b, c, d}, 0);

        // Single byte to b
        @(negedge clk);
        rst = 1'b0; out_ready = 4'b1111;
        in_valid = 1'b1; in_data = 8'hF0; sel3 = 1'b0; sel1 = 1'b1;
        #1;
        chk("first_in_ready", 32'(in_ready), 1);
        after_edge();
        chk("first_out_valid", 32'(out_valid), 32'b0010);
        chk("first_b", 32'(b), 32'hF0);
        chk("first_acd", {a, c, d}, 0);
        @(negedge clk);
        in_valid = 1'b0;
        after_edge();
        chk("first_drained", 32'(out_valid), 0);

        // Walk all select combinations
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 8'(i);
            sel1 = i[2]; sel2 = i[1]; sel3 = i[0];
            after_edge();
            chk($sformatf("walk%0d_valid", i), 32'(out_valid), 32'(1 << walk_ch[i]));
            chk($sformatf("walk%0d_data", i), 32'(chan(walk_ch[i])), 32'(i));
        end
        @(negedge clk);
        in_valid = 1'b0;
        after_edge();

        // Back-pressure on c while d keeps flowing
        @(negedge clk);
        out_ready = 4'b1011;
        in_valid = 1'b1; in_data = 8'hAA; sel3 = 1'b1; sel2 = 1'b0; sel1 = 1'b0;
        after_edge();
        chk("bp_c_loaded", 32'(c), 32'hAA);
        chk("bp_c_valid", 32'(out_valid), 32'b0100);
        @(negedge clk);
        in_data = 8'h55;
        #1;
        chk("bp_stall_ready", 32'(in_ready), 0);
        after_edge();
        chk("bp_c_held", 32'(c), 32'hAA);
        @(negedge clk);
        in_data = 8'h3C; sel2 = 1'b1;
        #1;
        chk("bp_d_ready", 32'(in_ready), 1);
        after_edge();
        chk("bp_d_valid", 32'(out_valid), 32'b1100);
        chk("bp_d_data", 32'(d), 32'h3C);
        chk("bp_c_still", 32'(c), 32'hAA);
        @(negedge clk);
        in_data = 8'h55; sel2 = 1'b0;
        #1;
        chk("bp_c_blocked", 32'(in_ready), 0);
        out_ready = 4'b1111;
        #1;
        chk("bp_c_release", 32'(in_ready), 1);
        after_edge();
        chk("bp_c_new", 32'(c), 32'h55);
        chk("bp_valid_after", 32'(out_valid), 32'b0100);
        @(negedge clk);
        in_valid = 1'b0;
        after_edge();
        chk("bp_idle", 32'(out_valid), 0);

        // Back-to-back stream to a
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 8'h10 + 8'(i);
            sel3 = 1'b0; sel1 = 1'b0;
            #1;
            chk($sformatf("stream%0d_ready", i), 32'(in_ready), 1);
            after_edge();
            chk($sformatf("stream%0d_valid", i), 32'(out_valid), 32'b0001);
            chk($sformatf("stream%0d_a", i), 32'(a), 32'h10 + i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        after_edge();

        // Asynchronous reset with a and d full
        @(negedge clk);
        out_ready = 4'b0000;
        in_valid = 1'b1; in_data = 8'h11; sel3 = 1'b0; sel1 = 1'b0;
        after_edge();
        @(negedge clk);
        in_data = 8'h22; sel3 = 1'b1; sel2 = 1'b1;
        after_edge();
        chk("pre_rst_valid", 32'(out_valid), 32'b1001);
        chk("pre_rst_ad", {a, d}, 32'h1122);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_ad", {a, d}, 0);
        chk("arst_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        after_edge();
        chk("post_rst_valid", 32'(out_valid), 0);

`ifdef DEMUX_BUF_CNT_EN
        @(negedge clk);
        out_ready = 4'b1111;
        in_valid = 1'b1; in_data = 8'h5A; sel3 = 1'b0; sel1 = 1'b1;
        repeat (257) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        after_edge();
        chk("cnt_wrap", cnt, 32'h0000_0100);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
